// File: rtl/alu_share_arb.sv
// Shared ALU with a two-port round-robin front end and a single-entry response buffer.
// The package and the ALU itself live here so the block is self-contained.
package mypkg;
   typedef enum logic [3:0] {
      A_ADD  = 4'd0,
      A_SUB  = 4'd1,
      A_SLL  = 4'd2,
      A_SLT  = 4'd3,
      A_SLTU = 4'd4,
      A_XOR  = 4'd5,
      A_SRL  = 4'd6,
      A_SRA  = 4'd7,
      A_OR   = 4'd8,
      A_AND  = 4'd9,
      A_LUI  = 4'd10
   } alu_op_e;
endpackage

module alu #(
   parameter int WIDTH = 32
) (
   input  mypkg::alu_op_e     alu_op_i,
   input  logic [WIDTH-1:0]   alu_a_i,
   input  logic [WIDTH-1:0]   alu_b_i,
   output logic [WIDTH-1:0]   alu_data_o,
   output logic               bru_exp_o
);
   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic        [4:0]       w_shamt;

   assign w_a_s   = $signed(alu_a_i);
   assign w_b_s   = $signed(alu_b_i);
   assign w_shamt = alu_b_i[4:0];

   always_comb begin
      alu_data_o = '0;
      case (alu_op_i)
         mypkg::A_ADD:  alu_data_o = alu_a_i + alu_b_i;
         mypkg::A_SUB:  alu_data_o = alu_a_i - alu_b_i;
         mypkg::A_SLL:  alu_data_o = alu_a_i << w_shamt;
         mypkg::A_SLT:  alu_data_o = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
         mypkg::A_SLTU: alu_data_o = {{(WIDTH-1){1'b0}}, (alu_a_i < alu_b_i)};
         mypkg::A_XOR:  alu_data_o = alu_a_i ^ alu_b_i;
         mypkg::A_SRL:  alu_data_o = alu_a_i >> w_shamt;
         mypkg::A_SRA:  alu_data_o = $unsigned(w_a_s >>> w_shamt);
         mypkg::A_OR:   alu_data_o = alu_a_i | alu_b_i;
         mypkg::A_AND:  alu_data_o = alu_a_i & alu_b_i;
         mypkg::A_LUI:  alu_data_o = alu_b_i;
         default:       alu_data_o = '0;
      endcase
   end

   assign bru_exp_o = |alu_data_o;
endmodule

module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,

   input  logic               req0_valid_i,
   output logic               req0_ready_o,
   input  mypkg::alu_op_e     req0_op_i,
   input  logic [WIDTH-1:0]   req0_a_i,
   input  logic [WIDTH-1:0]   req0_b_i,

   input  logic               req1_valid_i,
   output logic               req1_ready_o,
   input  mypkg::alu_op_e     req1_op_i,
   input  logic [WIDTH-1:0]   req1_a_i,
   input  logic [WIDTH-1:0]   req1_b_i,

   output logic               rsp0_valid_o,
   input  logic               rsp0_ready_i,
   output logic [WIDTH-1:0]   rsp0_data_o,
   output logic               rsp0_nz_o,

   output logic               rsp1_valid_o,
   input  logic               rsp1_ready_i,
   output logic [WIDTH-1:0]   rsp1_data_o,
   output logic               rsp1_nz_o,

   output logic               busy_o
);
   typedef enum logic {S_IDLE, S_HOLD} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_own;
   logic                r_last;
   logic [WIDTH-1:0]    r_data;
   logic                r_nz;

   logic                w_rsp_acc;
   logic                w_free;
   logic                w_gnt_vld;
   logic                w_gnt;
   mypkg::alu_op_e      w_alu_op;
   logic [WIDTH-1:0]    w_alu_a;
   logic [WIDTH-1:0]    w_alu_b;
   logic [WIDTH-1:0]    w_alu_data;
   logic                w_alu_nz;

   // The buffer frees up in the same cycle its owner takes the response.
   assign w_rsp_acc = (r_state == S_HOLD) && (r_own ? rsp1_ready_i : rsp0_ready_i);
   assign w_free    = (r_state == S_IDLE) || w_rsp_acc;

   always_comb begin
      w_gnt_vld    = 1'b0;
      w_gnt        = 1'b0;
      w_state_nxt  = r_state;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      if (w_free) begin
         if (req0_valid_i && req1_valid_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_last;
         end else if (req0_valid_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
         end else if (req1_valid_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
         end
      end
      req0_ready_o = w_gnt_vld && !w_gnt;
      req1_ready_o = w_gnt_vld &&  w_gnt;
      if (w_gnt_vld) begin
         w_state_nxt = S_HOLD;
      end else if (w_rsp_acc) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Idle cycles park the ALU on ADD 0+0 so its inputs do not toggle.
   always_comb begin
      w_alu_op = mypkg::A_ADD;
      w_alu_a  = '0;
      w_alu_b  = '0;
      if (w_gnt_vld) begin
         if (w_gnt) begin
            w_alu_op = req1_op_i;
            w_alu_a  = req1_a_i;
            w_alu_b  = req1_b_i;
         end else begin
            w_alu_op = req0_op_i;
            w_alu_a  = req0_a_i;
            w_alu_b  = req0_b_i;
         end
      end
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .alu_op_i   (w_alu_op),
      .alu_a_i    (w_alu_a),
      .alu_b_i    (w_alu_b),
      .alu_data_o (w_alu_data),
      .bru_exp_o  (w_alu_nz)
   );

   // last starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_own  <= 1'b0;
         r_last <= 1'b1;
         r_data <= '0;
         r_nz   <= 1'b0;
      end else if (w_gnt_vld) begin
         r_own  <= w_gnt;
         r_last <= w_gnt;
         r_data <= w_alu_data;
         r_nz   <= w_alu_nz;
      end
   end

   assign busy_o       = (r_state == S_HOLD);
   assign rsp0_valid_o = busy_o && !r_own;
   assign rsp1_valid_o = busy_o &&  r_own;
   assign rsp0_data_o  = r_data;
   assign rsp1_data_o  = r_data;
   assign rsp0_nz_o    = r_nz;
   assign rsp1_nz_o    = r_nz;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table plus arbitration/backpressure/reset sequences.
module tb_alu_share_arb;
   import mypkg::*;

   logic          clk;
   logic          rst_n;
   logic          req0_valid, req0_ready;
   alu_op_e       req0_op;
   logic [31:0]   req0_a, req0_b;
   logic          req1_valid, req1_ready;
   alu_op_e       req1_op;
   logic [31:0]   req1_a, req1_b;
   logic          rsp0_valid, rsp0_ready, rsp0_nz;
   logic [31:0]   rsp0_data;
   logic          rsp1_valid, rsp1_ready, rsp1_nz;
   logic [31:0]   rsp1_data;
   logic          busy;

   int n_chk = 0;
   int n_err = 0;

   alu_share_arb #(.WIDTH(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req0_valid_i (req0_valid),
      .req0_ready_o (req0_ready),
      .req0_op_i    (req0_op),
      .req0_a_i     (req0_a),
      .req0_b_i     (req0_b),
      .req1_valid_i (req1_valid),
      .req1_ready_o (req1_ready),
      .req1_op_i    (req1_op),
      .req1_a_i     (req1_a),
      .req1_b_i     (req1_b),
      .rsp0_valid_o (rsp0_valid),
      .rsp0_ready_i (rsp0_ready),
      .rsp0_data_o  (rsp0_data),
      .rsp0_nz_o    (rsp0_nz),
      .rsp1_valid_o (rsp1_valid),
      .rsp1_ready_i (rsp1_ready),
      .rsp1_data_o  (rsp1_data),
      .rsp1_nz_o    (rsp1_nz),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      alu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_d;
      logic        exp_nz;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input logic port, input logic vld, input alu_op_e op,
                          input logic [31:0] a, input logic [31:0] b);
      if (port == 1'b0) begin
         req0_valid = vld; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = vld; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, A_ADD,  32'd5,        32'd7,        32'd12,       1'b1};
      vecs[1] = '{1'b0, A_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
      vecs[2] = '{1'b1, A_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b1};
      vecs[3] = '{1'b1, A_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b1};
      vecs[4] = '{1'b0, A_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b1};
      vecs[5] = '{1'b1, A_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b1};
      vecs[6] = '{1'b0, A_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b1};
      vecs[7] = '{1'b1, A_OR,   32'd0,        32'd0,        32'd0,        1'b0};
      vecs[8] = '{1'b0, A_SLL,  32'd1,        32'h25,       32'd32,       1'b1};
      vecs[9] = '{1'b1, A_LUI,  32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b1};

      rst_n = 1'b0;
      set_req(1'b0, 1'b0, A_ADD, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, A_ADD, 32'd0, 32'd0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;

      // Reset state
      #12;
      check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_data0",      rsp0_data,           32'd0);
      check("rst_nz1",        {31'd0, rsp1_nz},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_ready0", {31'd0, req0_ready}, 32'd0);
      check("idle_ready1", {31'd0, req1_ready}, 32'd0);

      // Tie after reset: requester 0 first, then strict alternation
      @(negedge clk);
      set_req(1'b0, 1'b1, A_SUB, 32'd3, 32'd3);
      set_req(1'b1, 1'b1, A_SRA, 32'h80000000, 32'd4);
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("tie_ready0_%0d", i), {31'd0, req0_ready}, {31'd0, (i % 2 == 0)});
         check($sformatf("tie_ready1_%0d", i), {31'd0, req1_ready}, {31'd0, (i % 2 == 1)});
         @(negedge clk);
         #1;
         check($sformatf("tie_rsp0v_%0d", i), {31'd0, rsp0_valid}, {31'd0, (i % 2 == 0)});
         check($sformatf("tie_rsp1v_%0d", i), {31'd0, rsp1_valid}, {31'd0, (i % 2 == 1)});
         if (i % 2 == 0) begin
            check($sformatf("tie_data0_%0d", i), rsp0_data, 32'd0);
            check($sformatf("tie_nz0_%0d", i), {31'd0, rsp0_nz}, 32'd0);
         end else begin
            check($sformatf("tie_data1_%0d", i), rsp1_data, 32'hF8000000);
            check($sformatf("tie_nz1_%0d", i), {31'd0, rsp1_nz}, 32'd1);
         end
      end
      set_req(1'b0, 1'b0, A_ADD, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, A_ADD, 32'd0, 32'd0);

      // Single-operation vectors
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_req(vecs[i].port, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         #1;
         check($sformatf("v%0d_ready_own", i),
               {31'd0, (vecs[i].port ? req1_ready : req0_ready)}, 32'd1);
         check($sformatf("v%0d_ready_oth", i),
               {31'd0, (vecs[i].port ? req0_ready : req1_ready)}, 32'd0);
         @(negedge clk);
         set_req(vecs[i].port, 1'b0, A_ADD, 32'd0, 32'd0);
         #1;
         check($sformatf("v%0d_valid_own", i),
               {31'd0, (vecs[i].port ? rsp1_valid : rsp0_valid)}, 32'd1);
         check($sformatf("v%0d_valid_oth", i),
               {31'd0, (vecs[i].port ? rsp0_valid : rsp1_valid)}, 32'd0);
         check($sformatf("v%0d_data", i), (vecs[i].port ? rsp1_data : rsp0_data), vecs[i].exp_d);
         check($sformatf("v%0d_nz", i), {31'd0, (vecs[i].port ? rsp1_nz : rsp0_nz)},
               {31'd0, vecs[i].exp_nz});
      end

      // Backpressure on response 0 blocks requester 1
      @(negedge clk);
      rsp0_ready = 1'b0;
      set_req(1'b0, 1'b1, A_XOR, 32'hFF, 32'h0F);
      #1;
      check("bp_ready0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, A_ADD, 32'd0, 32'd0);
      set_req(1'b1, 1'b1, A_ADD, 32'd2, 32'd3);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_valid0_%0d", i), {31'd0, rsp0_valid}, 32'd1);
         check($sformatf("bp_data0_%0d", i),  rsp0_data,           32'h000000F0);
         check($sformatf("bp_busy_%0d", i),   {31'd0, busy},       32'd1);
         check($sformatf("bp_rdy0_%0d", i),   {31'd0, req0_ready}, 32'd0);
         check($sformatf("bp_rdy1_%0d", i),   {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      #1;
      check("bp_release_rdy1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      set_req(1'b1, 1'b0, A_ADD, 32'd0, 32'd0);
      #1;
      check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("bp_rsp1_data",  rsp1_data,           32'd5);

      // Streaming: one SLL per cycle, no bubbles
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         set_req(1'b1, 1'b1, A_SLL, 32'd1, k);
         #1;
         check($sformatf("st_ready_%0d", k), {31'd0, req1_ready}, 32'd1);
         @(negedge clk);
         #1;
         check($sformatf("st_valid_%0d", k), {31'd0, rsp1_valid}, 32'd1);
         check($sformatf("st_data_%0d", k),  rsp1_data,           32'd1 << k);
      end
      set_req(1'b1, 1'b0, A_ADD, 32'd0, 32'd0);

      // Reset while holding a response
      @(negedge clk);
      set_req(1'b1, 1'b1, A_LUI, 32'd0, 32'h12345000);
      @(negedge clk);
      set_req(1'b1, 1'b0, A_ADD, 32'd0, 32'd0);
      rsp1_ready = 1'b0;
      #1;
      check("mr_valid_before", {31'd0, rsp1_valid}, 32'd1);
      check("mr_data_before",  rsp1_data,           32'h12345000);
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_valid_async", {31'd0, rsp1_valid}, 32'd0);
      check("mr_data_async",  rsp1_data,           32'd0);
      check("mr_busy_async",  {31'd0, busy},       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("mr_after_v1_%0d", i), {31'd0, rsp1_valid}, 32'd0);
         check($sformatf("mr_after_v0_%0d", i), {31'd0, rsp0_valid}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
